// File: rtl/seq_detector_pkg.sv
// Shared types and constants for the 1011 serial pattern detector.
package seq_detector_pkg;

  localparam int unsigned ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector.sv
// Moore detector for serial pattern 1011 with registered detect pulse and match counter.
// Define SEQDET_OVERLAP_EN to let the trailing '1' of a match seed the next match.
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear,
  output logic             detect,
  output logic [CNT_W-1:0] match_count,
  output logic [ST_W-1:0]  state
);

  state_t state_q;
  state_t state_d;
  logic   detect_q;
  logic   detect_d;

  // Next-state and detect: clear wins over any valid bit, including a completing one.
  always_comb begin
    state_d  = state_q;
    detect_d = 1'b0;
    if (clear) begin
      state_d = S0;
    end else if (bit_valid) begin
      case (state_q)
        S0: state_d = bit_in ? S1 : S0;
        S1: state_d = bit_in ? S1 : S2;
        S2: state_d = bit_in ? S3 : S0;
        S3: state_d = bit_in ? S4 : S2;
`ifdef SEQDET_OVERLAP_EN
        S4: state_d = bit_in ? S1 : S2;
`else
        S4: state_d = bit_in ? S1 : S0;
`endif
        default: state_d = S0;
      endcase
      detect_d = (state_d == S4);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S0;
      detect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      detect_q <= detect_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (clear),
    .inc    (detect_d),
    .count  (match_count)
  );

  assign detect = detect_q;
  assign state  = state_q;

endmodule
